// File: rtl/freq_sweep_ctrl.sv
// ============================================================================
// freq_sweep_ctrl
//   Steps the clock-divider period value from start to stop, switching only at
//   divider period boundaries. Optional macro: SWEEP_LOOP_EN (loop restart).
//   Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module freq_sweep_ctrl #(
    parameter int VW = 24,
    parameter int SW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [VW-1:0] cfg_start_i,
    input  logic [VW-1:0] cfg_stop_i,
    input  logic [SW-1:0] cfg_step_i,
    input  logic [SW-1:0] cfg_dwell_i,
    input  logic          cfg_enable_i,
    input  logic          cfg_loop_i,
    input  logic          cfg_strobe_i,
    input  logic          sig_edge_i,
    output logic [VW-1:0] div_value_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [1:0]    state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_DWELL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [VW-1:0] div_q, div_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [VW-1:0] start_q, stop_q;
    logic [SW-1:0] step_q, dwell_q;
    logic          up_q;

`ifdef SWEEP_LOOP_EN
    logic          loop_q;
`else
    logic          cfg_loop_unused;
    assign cfg_loop_unused = cfg_loop_i;
`endif

    logic [SW-1:0] step_eff, dwell_eff;
    logic [VW:0]   step_ext, sum_ext, diff_ext, stop_ext;
    logic [VW-1:0] next_val;

    // Arithmetic carried at VW+1 bits so overshoot is detected instead of wrapping.
    always_comb begin
        step_eff  = (step_q  == '0) ? SW'(1) : step_q;
        dwell_eff = (dwell_q == '0) ? SW'(1) : dwell_q;
        step_ext  = {{(VW+1-SW){1'b0}}, step_eff};
        stop_ext  = {1'b0, stop_q};
        sum_ext   = {1'b0, div_q} + step_ext;
        diff_ext  = {1'b0, div_q} - step_ext;
        if (up_q) begin
            next_val = (sum_ext > stop_ext) ? stop_q : sum_ext[VW-1:0];
        end else begin
            next_val = (diff_ext[VW] || (diff_ext < stop_ext)) ? stop_q : diff_ext[VW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (cfg_strobe_i) begin
            state_d = cfg_enable_i ? S_ARM : S_IDLE;
        end else if (sig_edge_i) begin
            case (state_q)
                S_ARM: begin
                    div_d   = start_q;
                    cnt_d   = dwell_eff;
                    state_d = S_DWELL;
                end
                S_DWELL: begin
                    if (cnt_q > SW'(1)) begin
                        cnt_d = cnt_q - SW'(1);
                    end else if (div_q != stop_q) begin
                        div_d = next_val;
                        cnt_d = dwell_eff;
                    end else begin
                        done_d = 1'b1;
`ifdef SWEEP_LOOP_EN
                        if (loop_q) begin
                            div_d = start_q;
                            cnt_d = dwell_eff;
                        end else begin
                            state_d = S_DONE;
                        end
`else
                        state_d = S_DONE;
`endif
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d == S_ARM) || (state_d == S_DWELL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '1;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            up_q    <= 1'b0;
`ifdef SWEEP_LOOP_EN
            loop_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (cfg_strobe_i) begin
                start_q <= cfg_start_i;
                stop_q  <= cfg_stop_i;
                step_q  <= cfg_step_i;
                dwell_q <= cfg_dwell_i;
                up_q    <= (cfg_stop_i >= cfg_start_i);
`ifdef SWEEP_LOOP_EN
                loop_q  <= cfg_loop_i;
`endif
            end
        end
    end

    assign div_value_o = div_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign state_o     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_freq_sweep_ctrl.sv
// ============================================================================
// tb_freq_sweep_ctrl
//   Directed and randomized checks of freq_sweep_ctrl against a value-list model.
//   Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_freq_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] cfg_start = '0, cfg_stop = '0;
    logic [15:0] cfg_step = '0, cfg_dwell = '0;
    logic        cfg_enable = 1'b0, cfg_loop = 1'b0, cfg_strobe = 1'b0, sig_edge = 1'b0;
    logic [23:0] div_value;
    logic        busy, done;
    logic [1:0]  state;

    freq_sweep_ctrl #(.VW(24), .SW(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_start_i(cfg_start), .cfg_stop_i(cfg_stop),
        .cfg_step_i(cfg_step), .cfg_dwell_i(cfg_dwell),
        .cfg_enable_i(cfg_enable), .cfg_loop_i(cfg_loop),
        .cfg_strobe_i(cfg_strobe), .sig_edge_i(sig_edge),
        .div_value_o(div_value), .busy_o(busy), .done_o(done), .state_o(state)
    );

    always #5 clk = ~clk;

`ifdef SWEEP_LOOP_EN
    localparam bit LOOP_ON = 1'b1;
`else
    localparam bit LOOP_ON = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Model: on commit the whole list of divider values is built up front;
    // afterwards the sweep is just an index into that list plus an edge count.
    logic [23:0] seq[$];
    logic [23:0] mdiv = '1;
    int          mstate = 0;
    int          midx = 0, mheld = 0, mdwell = 1;
    bit          mloop = 1'b0, mdone = 1'b0, started = 1'b0;

    function automatic void build_seq(input logic [23:0] s, input logic [23:0] e, input logic [15:0] st);
        longint v, ee, stp;
        seq.delete();
        stp = longint'(st);
        if (stp == 0) stp = 1;
        v  = longint'(s);
        ee = longint'(e);
        seq.push_back(s);
        while (v != ee) begin
            if (e >= s) v = (v + stp > ee) ? ee : v + stp;
            else        v = (v - stp < ee) ? ee : v - stp;
            seq.push_back(v[23:0]);
        end
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        mdone   = 1'b0;
        if (rst) begin
            mstate = 0;
            mdiv   = '1;
            seq.delete();
        end else if (cfg_strobe) begin
            build_seq(cfg_start, cfg_stop, cfg_step);
            mdwell = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
            mloop  = cfg_loop;
            mstate = cfg_enable ? 1 : 0;
        end else if (sig_edge) begin
            if (mstate == 1) begin
                midx = 0; mheld = 0; mdiv = seq[0]; mstate = 2;
            end else if (mstate == 2) begin
                mheld++;
                if (mheld == mdwell) begin
                    mheld = 0;
                    if (midx < seq.size() - 1) begin
                        midx++;
                        mdiv = seq[midx];
                    end else begin
                        mdone = 1'b1;
                        if (LOOP_ON && mloop) begin
                            midx = 0;
                            mdiv = seq[0];
                        end else begin
                            mstate = 3;
                        end
                    end
                end
            end
        end
    end

    logic [23:0] obs[$];
    logic [23:0] last_div = '1;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (started) begin
            vectors++;
            if (div_value !== mdiv) begin
                miscompares++;
                $display("FAIL div_value @%0t: got %h expected %h", $time, div_value, mdiv);
            end
            if (state !== mstate[1:0]) begin
                miscompares++;
                $display("FAIL state @%0t: got %0d expected %0d", $time, state, mstate);
            end
            if (busy !== (mstate == 1 || mstate == 2)) begin
                miscompares++;
                $display("FAIL busy @%0t: got %b expected %b", $time, busy, (mstate == 1 || mstate == 2));
            end
            if (done !== mdone) begin
                miscompares++;
                $display("FAIL done @%0t: got %b expected %b", $time, done, mdone);
            end
            if (div_value !== last_div) begin
                obs.push_back(div_value);
                last_div = div_value;
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    logic [23:0] exp_q[$];

    task automatic check_seq(input string nm);
        check_lit({nm, " length"}, obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            check_lit($sformatf("%s[%0d]", nm, i), obs[i], exp_q[i]);
    endtask

    task automatic start_obs();
        obs.delete();
        last_div = div_value;
        done_cnt = 0;
    endtask

    task automatic commit(input logic [23:0] s, input logic [23:0] e, input logic [15:0] st,
                          input logic [15:0] dw, input logic en, input logic lp);
        cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = dw;
        cfg_enable = en; cfg_loop = lp; cfg_strobe = 1'b1;
        tick();
        cfg_strobe = 1'b0;
    endtask

    task automatic edges(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            repeat (gap - 1) tick();
            sig_edge = 1'b1;
            tick();
            sig_edge = 1'b0;
        end
    endtask

    logic [23:0] prev_div;

    initial begin
        repeat (3) tick();
        check_lit("reset div_value", div_value, 24'hFFFFFF);
        check_lit("reset state", state, 0);
        check_lit("reset busy", busy, 0);
        rst = 1'b0;
        tick();

        // Basic up sweep
        start_obs();
        commit(24'd100, 24'd130, 16'd10, 16'd2, 1'b1, 1'b0);
        check_lit("strobe->ARM state", state, 1);
        check_lit("strobe->ARM busy", busy, 1);
        edges(11, 20);
        exp_q = {24'd100, 24'd110, 24'd120, 24'd130};
        check_seq("up sweep");
        check_lit("up done pulses", done_cnt, 1);
        check_lit("up final state", state, 3);
        check_lit("up final div", div_value, 130);

        // Clamp on overshoot
        start_obs();
        commit(24'd100, 24'd125, 16'd10, 16'd1, 1'b1, 1'b0);
        edges(6, 7);
        exp_q = {24'd100, 24'd110, 24'd120, 24'd125};
        check_seq("clamp");
        check_lit("clamp state", state, 3);

        // Down sweep with dwell=0, then step=0
        start_obs();
        commit(24'd50, 24'd20, 16'd15, 16'd0, 1'b1, 1'b0);
        edges(5, 3);
        exp_q = {24'd50, 24'd35, 24'd20};
        check_seq("down");
        start_obs();
        commit(24'd3, 24'd1, 16'd0, 16'd0, 1'b1, 1'b0);
        edges(5, 3);
        exp_q = {24'd3, 24'd2, 24'd1};
        check_seq("step0");
        check_lit("step0 done pulses", done_cnt, 1);

        // Range extremes: no wrap at zero or at full scale
        start_obs();
        commit(24'd5, 24'd0, 16'd100, 16'd1, 1'b1, 1'b0);
        edges(4, 2);
        exp_q = {24'd5, 24'd0};
        check_seq("floor");
        start_obs();
        commit(24'hFFFFF0, 24'hFFFFFF, 16'd100, 16'd1, 1'b1, 1'b0);
        edges(4, 2);
        exp_q = {24'hFFFFF0, 24'hFFFFFF};
        check_seq("ceiling");

        // Abort coinciding with sig_edge
        commit(24'd100, 24'd200, 16'd10, 16'd3, 1'b1, 1'b0);
        edges(4, 5);
        start_obs();
        prev_div = div_value;
        cfg_enable = 1'b0; cfg_strobe = 1'b1; sig_edge = 1'b1;
        tick();
        cfg_strobe = 1'b0; sig_edge = 1'b0;
        check_lit("abort state", state, 0);
        check_lit("abort busy", busy, 0);
        check_lit("abort div held", div_value, prev_div);
        check_lit("abort div value", div_value, 110);
        edges(3, 3);
        check_lit("abort no done", done_cnt, 0);

        // Reset mid-dwell with a coincident edge
        commit(24'd100, 24'd200, 16'd10, 16'd3, 1'b1, 1'b0);
        edges(3, 4);
        rst = 1'b1; sig_edge = 1'b1;
        tick();
        rst = 1'b0; sig_edge = 1'b0;
        check_lit("rst div_value", div_value, 24'hFFFFFF);
        check_lit("rst state", state, 0);
        tick();

        // Loop request
        start_obs();
        commit(24'd10, 24'd12, 16'd1, 16'd1, 1'b1, 1'b1);
        edges(8, 3);
        if (LOOP_ON) begin
            exp_q = {24'd10, 24'd11, 24'd12, 24'd10, 24'd11, 24'd12, 24'd10, 24'd11};
            check_seq("loop");
            check_lit("loop done pulses", done_cnt, 2);
            check_lit("loop state", state, 2);
        end else begin
            exp_q = {24'd10, 24'd11, 24'd12};
            check_seq("no-loop");
            check_lit("no-loop done pulses", done_cnt, 1);
            check_lit("no-loop state", state, 3);
        end
        commit('0, '0, '0, '0, 1'b0, 1'b0);

        // Randomized traffic: edges, restarts, aborts, occasional reset
        for (int c = 0; c < 3000; c++) begin
            sig_edge = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 59) == 0) begin
                cfg_start  = 24'($urandom_range(0, 300));
                cfg_stop   = 24'($urandom_range(0, 300));
                cfg_step   = 16'($urandom_range(0, 40));
                cfg_dwell  = 16'($urandom_range(0, 3));
                cfg_enable = ($urandom_range(0, 4) != 0);
                cfg_loop   = $urandom_range(0, 1) == 1;
                cfg_strobe = 1'b1;
            end else begin
                cfg_strobe = 1'b0;
            end
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; sig_edge = 1'b0; cfg_strobe = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/freq_sweep_ctrl.md
# freq_sweep_ctrl

Sequencer for the 24-bit clock-divider period value. Host software writes sweep parameters through the I2C register file and pulses a commit strobe. The block then steps the divider value from a start to a stop value, holding each value for a programmable number of output periods. All value changes are applied only at divider period boundaries, so the sig1 output stays glitch-free.

## Interface
Parameters:
- VW, 24, divider value width
- SW, 16, step and dwell width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_start  in  VW  first divider value
- cfg_stop  in  VW  last divider value
- cfg_step  in  SW  step magnitude; 0 treated as 1
- cfg_dwell  in  SW  divider periods per value; 0 treated as 1
- cfg_enable  in  1  sampled on cfg_strobe; 1 = run, 0 = abort
- cfg_loop  in  1  sampled on cfg_strobe; restart after stop (SWEEP_LOOP_EN only)
- cfg_strobe  in  1  one-cycle commit pulse from the I2C write path
- sig_edge  in  1  one-cycle pulse at each divider period boundary
- div_value  out  VW  value driven to the clock divider
- busy  out  1  high in ARM or DWELL
- done  out  1  one-cycle pulse when the sweep finishes
- state  out  2  IDLE=0, ARM=1, DWELL=2, DONE=3; for status readback

## Operation
- Reset values: div_value=24'hFFFFFF, state=IDLE, busy=0, done=0, dwell counter=0, all latched config=0.
- On cfg_strobe, the block latches start, stop, step, dwell, enable and loop. Direction is latched as up when stop ≥ start, otherwise down.
- **IDLE**
  - cfg_strobe with enable=1 → ARM.
  - Otherwise hold div_value.
- **ARM**
  - Wait for sig_edge.
  - On sig_edge: div_value←start, cnt←max(dwell,1), → DWELL.
- **DWELL**, on each sig_edge:
  - If cnt>1: cnt←cnt−1.
  - If cnt==1 and cur≠stop: div_value←next, cnt←max(dwell,1).
  - If cnt==1 and cur==stop: go to DONE with a done pulse. When loop is set and SWEEP_LOOP_EN is defined, instead set div_value←start and cnt←max(dwell,1), pulse done, and stay in DWELL.
- **Next-value arithmetic:**
  - Step is zero-extended to VW bits.
  - Up: next = min(cur+step, stop).
  - Down: next = max(cur−step, stop).
  - Intermediates are computed at VW+1 bits, so no wrap-around occurs and the final value always equals stop exactly.
- **DONE**
  - Hold div_value=stop.
  - cfg_strobe with enable=1 → ARM; with enable=0 → IDLE.
- **Abort:** cfg_strobe with enable=0 in any state → IDLE. div_value holds its current value; done is not pulsed.
- **Restart:** cfg_strobe with enable=1 in ARM or DWELL → ARM with the new config. div_value holds until the next sig_edge.
- **Simultaneous cfg_strobe and sig_edge:** the strobe wins and that sig_edge is ignored.
- **start==stop:** the sweep applies one value, then reaches DONE after dwell periods.

## Timing
- All outputs are registered.
- div_value changes exactly one clk after the sig_edge cycle that causes the change.
- done is asserted in the same cycle as the state change to DONE, and lasts one cycle.
- cfg_strobe in cycle N → state=ARM and busy=1 in cycle N+1.
- Abort strobe in cycle N → state=IDLE and busy=0 in cycle N+1.
- rst asserted mid-sweep → reset values in the next cycle; any pending sig_edge is discarded.
- Each value is held for exactly max(dwell,1) divider periods, counted in sig_edge pulses.

## Configuration
- **SWEEP_LOOP_EN defined:** the cfg_loop bit is honoured. At the end of the sweep the block pulses done, reloads start and keeps running until aborted or restarted.
- **SWEEP_LOOP_EN undefined:** the cfg_loop bit is ignored, the sweep always ends in DONE, and the loop logic is not synthesised.

## Test plan
- **Basic up sweep.** Stimulus: start=100, stop=130, step=10, dwell=2, enable=1, then sig_edge every 20 clk. Required: div_value sequence 100,110,120,130, each held for 2 edges; done pulses once; state=DONE; div_value stays 130.
- **Clamp on overshoot.** Stimulus: start=100, stop=125, step=10, dwell=1. Required: div_value sequence 100,110,120,125, then DONE.
- **Down sweep and zero fields.** Stimulus: start=50, stop=20, step=15, dwell=0. Required: div_value sequence 50,35,20, each held for 1 edge. Then stimulus: step=0, start=3, stop=1. Required: div_value sequence 3,2,1.
- **Abort and strobe priority.** Stimulus: abort strobe mid-DWELL, issued in the same cycle as sig_edge. Required: state=IDLE next cycle, div_value unchanged, no done pulse. Then stimulus: rst during DWELL. Required: div_value=24'hFFFFFF.
- **Loop with SWEEP_LOOP_EN.** Stimulus: start=10, stop=12, step=1, dwell=1, loop=1. Required: div_value sequence 10,11,12,10,11,… with done pulsing at each wrap. With the macro undefined, the same stimulus stops in DONE at 12.
